// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types and helpers for the fetch-side branch predictor:
//   - 2-bit saturating counter encodings
//   - the prediction record carried F->D->E
//   - table update opcodes passed from the resolver to the storage
//   - PC index/tag slicing and the counter next-state function
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_t;

  localparam pred_t PRED_NONE = '{taken: 1'b0, target: 32'h0000_0000};

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10,
    CNT_SET  = 2'b11
  } cnt_op_e;

  typedef enum logic [1:0] {
    BTB_HOLD  = 2'b00,
    BTB_WRITE = 2'b01,
    BTB_INVAL = 2'b10
  } btb_op_e;

  // Table index: PC word address modulo the table size.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_bits);
    return (pc >> 32'd2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  // BTB tag: everything above the index bits.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 32'd2);
  endfunction

  // Saturating 2-bit counter step; CNT_SET jumps straight to strongly taken.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input cnt_op_e op);
    logic [1:0] nxt;
    case (op)
      CNT_INC:  nxt = (cnt == ST)  ? ST  : cnt + 2'd1;
      CNT_DEC:  nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
      CNT_SET:  nxt = ST;
      default:  nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Direct-mapped BHT (2-bit counters) and tagged BTB storage.
// One combinational read port (pre-write value on same-index collisions) and
// one write port carrying separate counter and BTB opcodes.
// Ports:
//   clk, rst            clock, async active-low reset (clears valid, counters
//                       to CNT_INIT)
//   rd_idx              lookup index
//   rd_valid/tag/cnt/target  entry contents at rd_idx
//   wr_idx              update index
//   wr_cnt_op           counter opcode (cnt_op_e)
//   wr_btb_op           BTB opcode (btb_op_e)
//   wr_tag, wr_target   BTB fill data
// -----------------------------------------------------------------------------
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_BITS = 6,
  parameter int         TAG_BITS = 30 - IDX_BITS,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [1:0]          rd_cnt,
  output logic [31:0]         rd_target,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [1:0]          wr_cnt_op,
  input  logic [1:0]          wr_btb_op,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_r;
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [31:0]         target_r [ENTRIES];
  logic [1:0]          cnt_r    [ENTRIES];

  assign rd_valid  = valid_r[rd_idx];
  assign rd_tag    = tag_r[rd_idx];
  assign rd_cnt    = cnt_r[rd_idx];
  assign rd_target = target_r[rd_idx];

  // BTB entry fill / invalidate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= 32'h0000_0000;
      end
    end else begin
      case (btb_op_e'(wr_btb_op))
        BTB_WRITE: begin
          valid_r[wr_idx]  <= 1'b1;
          tag_r[wr_idx]    <= wr_tag;
          target_r[wr_idx] <= wr_target;
        end
        BTB_INVAL: valid_r[wr_idx] <= 1'b0;
        default:   valid_r[wr_idx] <= valid_r[wr_idx];
      endcase
    end
  end

  // BHT counter update (read-modify-write at the write index)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= CNT_INIT;
      end
    end else begin
      cnt_r[wr_idx] <= cnt_next(cnt_r[wr_idx], cnt_op_e'(wr_cnt_op));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Fetch-side predictor lookup, F->D->E prediction pipeline, and E-stage
// resolver that raises Eval_branch with the corrected fetch PC.
// Ports:
//   clk, rst                 clock, async active-low reset
//   PCF                      fetch PC (lookup address)
//   StallD, FlushD, FlushE   hazard-unit controls for the prediction regs
//   BranchE, JumpE, TakenE   E-stage instruction class and outcome
//   PCE, PCTargetE, PCPlus4E E-stage PC, computed target, fall-through
//   PredTakenF, PredTargetF  fetch prediction
//   Eval_branch, PCCorrectE  mispredict flag and redirect PC
//   MispredCnt               saturating mispredict counter
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_BITS = 6,
  parameter int         TAG_BITS = 30 - IDX_BITS,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] PCPlus4E,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic        Eval_branch,
  output logic [31:0] PCCorrectE,
  output logic [31:0] MispredCnt
);

  logic [IDX_BITS-1:0] idx_f_s;
  logic [TAG_BITS-1:0] tag_f_s;
  logic [IDX_BITS-1:0] idx_e_s;
  logic [TAG_BITS-1:0] tag_e_s;

  logic                rd_valid_s;
  logic [TAG_BITS-1:0] rd_tag_s;
  logic [1:0]          rd_cnt_s;
  logic [31:0]         rd_target_s;
  logic                hit_s;

  pred_t               pred_f_s;
  pred_t               pred_d_r;
  pred_t               pred_e_r;

  logic                act_e_s;
  logic                eval_s;
  logic [31:0]         pc_correct_s;
  logic [1:0]          cnt_op_s;
  logic [1:0]          btb_op_s;
  logic [31:0]         mispred_cnt_r;

  assign idx_f_s = IDX_BITS'(pc_index(PCF, IDX_BITS));
  assign tag_f_s = TAG_BITS'(pc_tag(PCF, IDX_BITS));
  assign idx_e_s = IDX_BITS'(pc_index(PCE, IDX_BITS));
  assign tag_e_s = TAG_BITS'(pc_tag(PCE, IDX_BITS));

  bp_table #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx_f_s),
    .rd_valid  (rd_valid_s),
    .rd_tag    (rd_tag_s),
    .rd_cnt    (rd_cnt_s),
    .rd_target (rd_target_s),
    .wr_idx    (idx_e_s),
    .wr_cnt_op (cnt_op_s),
    .wr_btb_op (btb_op_s),
    .wr_tag    (tag_e_s),
    .wr_target (PCTargetE)
  );

  // Fetch lookup: a miss predicts not-taken with a zero target.
  always_comb begin
    hit_s           = rd_valid_s && (rd_tag_s == tag_f_s);
    pred_f_s        = PRED_NONE;
    if (hit_s) begin
      pred_f_s.taken  = rd_cnt_s[1];
      pred_f_s.target = rd_target_s;
    end else begin
      pred_f_s        = PRED_NONE;
    end
  end

  assign PredTakenF  = pred_f_s.taken;
  assign PredTargetF = pred_f_s.target;

  // Prediction pipeline; FlushD wins over StallD so a flushed slot never survives a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_d_r <= PRED_NONE;
      pred_e_r <= PRED_NONE;
    end else begin
      if (FlushD) begin
        pred_d_r <= PRED_NONE;
      end else if (StallD) begin
        pred_d_r <= pred_d_r;
      end else begin
        pred_d_r <= pred_f_s;
      end
      if (FlushE) begin
        pred_e_r <= PRED_NONE;
      end else begin
        pred_e_r <= pred_d_r;
      end
    end
  end

  assign act_e_s = JumpE | (BranchE & TakenE);

  // Resolve: direction mismatch, or taken-both-ways with a stale target (jalr).
  always_comb begin
    eval_s       = 1'b0;
    pc_correct_s = PCPlus4E;
    if (pred_e_r.taken && !act_e_s) begin
      eval_s       = 1'b1;
      pc_correct_s = PCPlus4E;
    end else if (!pred_e_r.taken && act_e_s) begin
      eval_s       = 1'b1;
      pc_correct_s = PCTargetE;
    end else if (pred_e_r.taken && act_e_s && (pred_e_r.target != PCTargetE)) begin
      eval_s       = 1'b1;
      pc_correct_s = PCTargetE;
    end else begin
      eval_s       = 1'b0;
      pc_correct_s = PCPlus4E;
    end
  end

  assign Eval_branch = eval_s;
  assign PCCorrectE  = pc_correct_s;

  // Table update opcodes; a taken prediction on a non-control instruction is a BTB alias to drop.
  always_comb begin
    cnt_op_s = CNT_HOLD;
    btb_op_s = BTB_HOLD;
    if (JumpE) begin
      cnt_op_s = CNT_SET;
    end else if (BranchE) begin
      cnt_op_s = TakenE ? CNT_INC : CNT_DEC;
    end else begin
      cnt_op_s = CNT_HOLD;
    end
    if (act_e_s) begin
      btb_op_s = BTB_WRITE;
    end else if (pred_e_r.taken && !BranchE && !JumpE) begin
      btb_op_s = BTB_INVAL;
    end else begin
      btb_op_s = BTB_HOLD;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispred_cnt_r <= 32'h0000_0000;
    end else if (eval_s && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
      mispred_cnt_r <= mispred_cnt_r + 32'd1;
    end else begin
      mispred_cnt_r <= mispred_cnt_r;
    end
  end

  assign MispredCnt = mispred_cnt_r;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-side branch predictor and execute-side resolver for the 5-stage RISC-V pipeline. It uses a direct-mapped BHT of 2-bit saturating counters and a tagged BTB, looked up with PCF. It carries each prediction F->D->E in step with the pipeline registers. It compares the prediction with the actual outcome in E and drives Eval_branch, the mispredict flush request the hazard unit consumes, together with the corrected fetch PC.

Parameters:
IDX_BITS, 6, table index width; 2**IDX_BITS entries, index = PC[IDX_BITS+1:2]
TAG_BITS, 30-IDX_BITS, BTB tag = PC[31:IDX_BITS+2]
CNT_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
PCF  in  32  fetch PC
StallD  in  1  from hazard unit; holds the D-stage prediction register
FlushD  in  1  from hazard unit; clears the D-stage prediction register
FlushE  in  1  from hazard unit; clears the E-stage prediction register
BranchE  in  1  E-stage instruction is a conditional branch
JumpE  in  1  E-stage instruction is jal/jalr
TakenE  in  1  actual branch outcome in E (ignored unless BranchE)
PCE  in  32  E-stage PC
PCTargetE  in  32  actual target computed in E
PCPlus4E  in  32  PCE+4
PredTakenF  out  1  predict taken for PCF
PredTargetF  out  32  predicted target (BTB target, 0 when not hit)
Eval_branch  out  1  mispredict in E; causes FlushD/FlushE upstream
PCCorrectE  out  32  PC to fetch next when Eval_branch=1
MispredCnt  out  32  saturating mispredict count, for performance monitoring

Behaviour:
- Lookup is combinational on PCF. hit = valid[idx] && tag[idx]==PCF tag. PredTakenF = hit && cnt[idx][1]. PredTargetF = hit ? target[idx] : 0.
- Prediction pipeline regs {taken, target}: predD and predE.
  - predD: cleared on FlushD; otherwise held if StallD; otherwise loads {PredTakenF, PredTargetF}. FlushD has priority over StallD.
  - predE: cleared on FlushE; otherwise loads predD.
- Actual taken: actE = JumpE | (BranchE & TakenE).
- Eval_branch is combinational:
  - predE.taken & !actE -> 1, PCCorrectE = PCPlus4E. This includes a BTB alias on a non-branch instruction.
  - !predE.taken & actE -> 1, PCCorrectE = PCTargetE.
  - predE.taken & actE & predE.target != PCTargetE -> 1, PCCorrectE = PCTargetE. This covers a jalr target change.
  - Otherwise 0, and PCCorrectE = PCPlus4E.
- Table updates happen at the clock edge, for E-stage index/tag taken from PCE:
  - BranchE: counter saturating +1 if TakenE, -1 if not (limits 00 and 11).
  - JumpE: counter forced to 11.
  - actE: BTB entry written {valid=1, tag, PCTargetE}.
  - predE.taken and not BranchE/JumpE: BTB valid cleared for that index.
- A read and write to the same index in the same cycle: the lookup returns the pre-write value. Write-first forwarding is not performed.
- MispredCnt increments on each cycle with Eval_branch=1 and saturates at 32'hFFFF_FFFF.
- Reset (rst=0, asynchronous):
  - all valid bits cleared, counters set to CNT_INIT, predD/predE cleared, MispredCnt=0;
  - outputs therefore become PredTakenF=0, PredTargetF=0, Eval_branch=0, PCCorrectE=PCPlus4E.
  - Reset asserted mid-operation discards all history. The first post-reset branch predicts not-taken.
- Simultaneous Eval_branch and FlushD/FlushE: the flushes clear the younger predictions, so no stale prediction reaches E.

Decomposition:
- Shared package: the counter encodings SNT=00, WNT=01, WT=10, ST=11; a pred_t struct {taken, target[31:0]}; the index/tag slice helpers.
- Natural sub-module: bp_table. It holds the BHT and BTB storage, with one combinational read port, one write port and async clear. branch_predictor holds the prediction pipeline, resolve logic and counter.

Test Plan:
- Reset, then BranchE=1, TakenE=1, PCE=0x100, PCTargetE=0x180 -> Eval_branch=1, PCCorrectE=0x180. Next PCF=0x100 -> hit, counter 10, PredTakenF=1, PredTargetF=0x180.
- Repeat taken at 0x100 three times, then TakenE=0 -> counter goes 10->11->11 then 10. Eval_branch=1 on the not-taken resolve with PCCorrectE=0x104, and PredTakenF stays 1.
- Predicted-taken prediction in D with StallD=1 for 2 cycles -> predD held. With FlushD=1 and StallD=1 together -> predD cleared. FlushE=1 -> predE cleared and Eval_branch=0 for the bubble.
- jalr at PCE=0x200 trained to 0x300, then resolves to 0x340 -> Eval_branch=1, PCCorrectE=0x340, BTB target updated to 0x340.
- Alias: PCF=0x100+(1<<8) hits a stale tag? No, tag mismatch -> PredTakenF=0. Force a valid non-branch predicted taken in E -> Eval_branch=1, PCCorrectE=PCPlus4E, valid cleared.
- Drive rst=0 asynchronously between clock edges during training -> outputs reset immediately and MispredCnt=0. After release, branch 0x100 predicts not-taken.
